mutative_tag_array_nway: RTL

- Parametrised N-way, set-associative tag store for the mutative cache; successor to the single-port 128x20 tag macro model.
- Holds {valid, tag} per way per set, with per-way masked writes and a registered lookup that produces a per-way hit vector.
- Runs a self-clearing flush sweep after reset and on request, so the cache controller never sees stale valid bits.
- Sits between the cache controller FSM and the data array and is a drop-in for the tag path.

---
 rtl/mutative_tag_array_nway.sv | 112 +++++++++++
 1 files changed

// File: rtl/mutative_tag_array_nway.sv
// mutative_tag_array_nway: N-way set-associative {valid,tag} store with registered lookup and
// self-clearing flush sweep; optional even parity per entry under MUTATIVE_TAG_PARITY_EN
module mutative_tag_array_nway #(
   parameter int WAYS      = 4,
   parameter int SET_BITS  = 7,
   parameter int TAG_WIDTH = 20
) (
   input  logic                      clk0,
   input  logic                      rstb0,
   input  logic                      csb0,
   input  logic                      web0,
   input  logic [SET_BITS-1:0]       addr0,
   input  logic [TAG_WIDTH-1:0]      din0,
   input  logic                      vld0,
   input  logic [WAYS-1:0]           wmask0,
   input  logic                      flush0,
   output logic                      ready0,
   output logic [WAYS*TAG_WIDTH-1:0] dout0,
   output logic [WAYS-1:0]           vout0,
   output logic [WAYS-1:0]           hit0,
   output logic [WAYS-1:0]           perr0
);
   localparam int SETS = 1 << SET_BITS;
`ifdef MUTATIVE_TAG_PARITY_EN
   localparam int PW = 1;
`else
   localparam int PW = 0;
`endif
   localparam int EW = TAG_WIDTH + 1 + PW;

   typedef enum logic {FLUSH, IDLE} state_t;

   state_t                state, state_nx;
   logic [SET_BITS-1:0]   cnt, cnt_nx, addr_reg;
   logic [TAG_WIDTH-1:0]  din_reg;
   logic                  web_reg, vld_reg;
   logic [WAYS-1:0]       wmask_reg;
   logic [EW-1:0]         mem [SETS][WAYS];
   logic [EW-1:0]         wr_entry;

   assign ready0 = state == IDLE;

`ifdef MUTATIVE_TAG_PARITY_EN
   assign wr_entry = {^{vld_reg, din_reg}, vld_reg, din_reg};
`else
   assign wr_entry = {vld_reg, din_reg};
`endif

   // sweep sequencing: walk every set once, then idle until a flush request
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (state == FLUSH) begin
         cnt_nx   = cnt + 1'b1;
         state_nx = &cnt ? IDLE : FLUSH;
      end else if (flush0) begin
         state_nx = FLUSH;
         cnt_nx   = '0;
      end
   end

   // state and sweep counter; reset restarts the sweep from set 0
   always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) begin
         state <= FLUSH;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // request capture; an unaccepted cycle becomes a non-writing lookup of the held set
   always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) begin
         web_reg   <= 1'b1;
         addr_reg  <= '0;
         din_reg   <= '0;
         vld_reg   <= 1'b0;
         wmask_reg <= '0;
      end else if (!csb0 && ready0) begin
         web_reg   <= web0;
         addr_reg  <= addr0;
         din_reg   <= din0;
         vld_reg   <= vld0;
         wmask_reg <= wmask0;
      end else begin
         web_reg   <= 1'b1;
      end
   end

   // storage update; the sweep clear is last so it wins on a same-edge collision
   always_ff @(posedge clk0) begin
      for (int w = 0; w < WAYS; w++) begin
         if (!web_reg && wmask_reg[w]) mem[addr_reg][w] <= wr_entry;
         if (state == FLUSH) mem[cnt][w] <= '0;
      end
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic [EW-1:0] e;
      assign e = mem[addr_reg][w];
      assign dout0[w*TAG_WIDTH +: TAG_WIDTH] = ready0 ? e[TAG_WIDTH-1:0] : '0;
      assign vout0[w] = ready0 & e[TAG_WIDTH];
`ifdef MUTATIVE_TAG_PARITY_EN
      assign perr0[w] = ready0 & (^e);
`else
      assign perr0[w] = 1'b0;
`endif
      assign hit0[w] = vout0[w] & (e[TAG_WIDTH-1:0] == din_reg) & web_reg & ~perr0[w];
   end
endmodule
